// File: rtl/asg_seq_pkg.sv
// Shared types and config address map for the ASG frequency-sweep sequencer.
package asg_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ARM   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DWELL = 3'd4,
        ST_FIN   = 3'd5
    } seq_state_e;

    localparam logic [7:0] SEQ_A_LAST   = 8'h00;
    localparam logic [7:0] SEQ_A_SETTLE = 8'h04;
    localparam logic [7:0] SEQ_A_DWELL  = 8'h08;
    localparam logic [7:0] SEQ_A_TMO    = 8'h0C;
    localparam logic [7:0] SEQ_A_TBL    = 8'h40;

    // Cycles at the start of WAIT during which a stale measurement level is ignored.
    localparam logic [1:0] SEQ_BLANK_CYCLES = 2'd2;

    // A dwell of N lasts N cycles, with 0 treated as a single cycle.
    function automatic logic [31:0] dwellLoadValue(input logic [31:0] dwell);
        return (dwell == 32'd0) ? 32'd0 : dwell - 32'd1;
    endfunction

endpackage

// File: rtl/asg_seq_tbl.sv
// Step-word table: one write port, synchronous read with an enable so the
// output holds the last word read between points.
module asg_seq_tbl #(
    parameter int DW    = 30,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Only the read register is reset; the array contents survive a reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/asg_sweep_sequencer.sv
// Frequency-sweep scheduler for one ASG channel: walks a table of phase-step
// words, settling, triggering and waiting for a measurement at each point.
module asg_sweep_sequencer
    import asg_seq_pkg::*;
#(
    parameter int RSZ  = 14,
    parameter int NPTS = 16
) (
    input  logic                      dac_clk_i,
    input  logic                      dac_rst_i,
    input  logic                      cfg_we_i,
    input  logic [7:0]                cfg_addr_i,
    input  logic [31:0]               cfg_wdata_i,
    input  logic                      start_i,
    input  logic                      abort_i,
    input  logic                      meas_done_i,
    output logic [RSZ+15:0]           set_step_o,
    output logic                      set_rst_o,
    output logic                      trig_sw_o,
    output logic                      busy_o,
    output logic [$clog2(NPTS)-1:0]   pt_idx_o,
    output logic                      pt_strobe_o,
    output logic                      done_o,
    output logic                      err_o
);

    localparam int IW = $clog2(NPTS);
    localparam int SW = RSZ + 16;

    seq_state_e    r_state, w_nextState;
    logic [IW-1:0] r_lastIdx, r_idx, w_nextIdx, w_rdAddr;
    logic [15:0]   r_settle;
    logic [31:0]   r_dwell, r_tmo, r_cnt, w_nextCnt, w_dwellLoad;
    logic [1:0]    r_blank, w_nextBlank;
    logic          r_meas;
    logic          r_setRst, r_trig, r_busy, r_strobe, r_done, r_err;
    logic          w_strobe, w_setErr, w_clrErr, w_rdEn;
    logic          w_cfgWe, w_tblWe;
    logic [5:0]    w_tblOff;
    logic [SW-1:0] w_tblData;

    assign w_cfgWe     = cfg_we_i && !r_busy;
    assign w_tblOff    = cfg_addr_i[7:2] - SEQ_A_TBL[7:2];
    assign w_tblWe     = w_cfgWe && (cfg_addr_i >= SEQ_A_TBL) &&
                         (cfg_addr_i[1:0] == 2'b00) && (int'(w_tblOff) < NPTS);
    assign w_dwellLoad = dwellLoadValue(r_dwell);

    always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
        if (dac_rst_i) begin
            r_lastIdx <= '0;
            r_settle  <= '0;
            r_dwell   <= '0;
            r_tmo     <= '0;
        end else if (w_cfgWe) begin
            case (cfg_addr_i)
                SEQ_A_LAST:   r_lastIdx <= cfg_wdata_i[IW-1:0];
                SEQ_A_SETTLE: r_settle  <= cfg_wdata_i[15:0];
                SEQ_A_DWELL:  r_dwell   <= cfg_wdata_i;
                SEQ_A_TMO:    r_tmo     <= cfg_wdata_i;
                default: ;
            endcase
        end
    end

    asg_seq_tbl #(
        .DW    (SW),
        .DEPTH (NPTS),
        .AW    (IW)
    ) u_tbl (
        .i_clk   (dac_clk_i),
        .i_rst   (dac_rst_i),
        .i_we    (w_tblWe),
        .i_waddr (w_tblOff[IW-1:0]),
        .i_wdata (cfg_wdata_i[SW-1:0]),
        .i_re    (w_rdEn),
        .i_raddr (w_rdAddr),
        .o_rdata (w_tblData)
    );

    // One shared down-counter serves settle, timeout and dwell in turn.
    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        w_nextBlank = r_blank;
        w_nextIdx   = r_idx;
        w_strobe    = 1'b0;
        w_setErr    = 1'b0;
        w_clrErr    = 1'b0;
        w_rdEn      = 1'b0;
        w_rdAddr    = r_idx;
        case (r_state)
            ST_IDLE: begin
                if (start_i && !abort_i) begin
                    w_nextState = ST_LOAD;
                    w_nextIdx   = '0;
                    w_nextCnt   = {16'd0, r_settle};
                    w_clrErr    = 1'b1;
                    w_rdEn      = 1'b1;
                    w_rdAddr    = '0;
                end
            end
            ST_LOAD: begin
                if (r_cnt == 32'd0) begin
                    w_nextState = ST_ARM;
                end else begin
                    w_nextCnt = r_cnt - 32'd1;
                end
            end
            ST_ARM: begin
                w_nextState = ST_WAIT;
                w_nextCnt   = r_tmo;
                w_nextBlank = SEQ_BLANK_CYCLES;
            end
            ST_WAIT: begin
                if (r_blank != 2'd0) begin
                    w_nextBlank = r_blank - 2'd1;
                end
                if (r_blank == 2'd0 && r_meas) begin
                    w_strobe    = 1'b1;
                    w_nextState = ST_DWELL;
                    w_nextCnt   = w_dwellLoad;
                end else if (r_tmo != 32'd0 && r_cnt == 32'd0) begin
                    w_setErr    = 1'b1;
                    w_nextState = ST_DWELL;
                    w_nextCnt   = w_dwellLoad;
                end else if (r_cnt != 32'd0) begin
                    w_nextCnt = r_cnt - 32'd1;
                end
            end
            ST_DWELL: begin
                if (r_cnt != 32'd0) begin
                    w_nextCnt = r_cnt - 32'd1;
                end else if (r_idx == r_lastIdx) begin
                    w_nextState = ST_FIN;
                end else begin
                    w_nextState = ST_LOAD;
                    w_nextIdx   = r_idx + IW'(1);
                    w_nextCnt   = {16'd0, r_settle};
                    w_rdEn      = 1'b1;
                    w_rdAddr    = r_idx + IW'(1);
                end
            end
            ST_FIN: begin
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
        if (abort_i && r_state != ST_IDLE) begin
            w_nextState = ST_IDLE;
            w_nextCnt   = r_cnt;
            w_nextIdx   = r_idx;
            w_strobe    = 1'b0;
            w_setErr    = 1'b0;
            w_rdEn      = 1'b0;
        end
    end

    // Outputs are decoded from the next state so every one of them is a flop.
    always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
        if (dac_rst_i) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_blank  <= '0;
            r_idx    <= '0;
            r_meas   <= 1'b0;
            r_setRst <= 1'b0;
            r_trig   <= 1'b0;
            r_busy   <= 1'b0;
            r_strobe <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_cnt    <= w_nextCnt;
            r_blank  <= w_nextBlank;
            r_idx    <= w_nextIdx;
            r_meas   <= meas_done_i;
            r_setRst <= (w_nextState == ST_LOAD);
            r_trig   <= (w_nextState == ST_ARM);
            r_busy   <= (w_nextState != ST_IDLE);
            r_strobe <= w_strobe;
            r_done   <= (w_nextState == ST_FIN);
            if (w_clrErr) begin
                r_err <= 1'b0;
            end else if (w_setErr) begin
                r_err <= 1'b1;
            end
        end
    end

    assign set_step_o  = w_tblData;
    assign set_rst_o   = r_setRst;
    assign trig_sw_o   = r_trig;
    assign busy_o      = r_busy;
    assign pt_idx_o    = r_idx;
    assign pt_strobe_o = r_strobe;
    assign done_o      = r_done;
    assign err_o       = r_err;

endmodule

// File: tb/tb_asg_sweep_sequencer.sv
// Scoreboard bench for asg_sweep_sequencer: directed sweeps push expected
// trigger/strobe/error/done events; a monitor pops and compares them.
module tb_asg_sweep_sequencer;

    localparam int RSZ  = 14;
    localparam int NPTS = 16;
    localparam int IW   = 4;
    localparam int SW   = RSZ + 16;

    localparam int K_TRIG   = 0;
    localparam int K_STROBE = 1;
    localparam int K_DONE   = 2;
    localparam int K_ERR    = 3;

    typedef struct {
        int            kind;
        logic [SW-1:0] step;
        logic [IW-1:0] idx;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfgWe;
    logic [7:0]    cfgAddr;
    logic [31:0]   cfgWdata;
    logic          start;
    logic          abort;
    logic          meas;
    logic [SW-1:0] setStep;
    logic          setRst;
    logic          trigSw;
    logic          busy;
    logic [IW-1:0] ptIdx;
    logic          ptStrobe;
    logic          done;
    logic          err;

    exp_t expQ[$];
    int   nVectors     = 0;
    int   nMiscompares = 0;
    int   respMode     = 0;
    int   respDelay    = 10;
    logic prevErr      = 1'b0;
    int   n;

    always #5 clk = ~clk;

    asg_sweep_sequencer #(.RSZ(RSZ), .NPTS(NPTS)) dut (
        .dac_clk_i   (clk),
        .dac_rst_i   (rst),
        .cfg_we_i    (cfgWe),
        .cfg_addr_i  (cfgAddr),
        .cfg_wdata_i (cfgWdata),
        .start_i     (start),
        .abort_i     (abort),
        .meas_done_i (meas),
        .set_step_o  (setStep),
        .set_rst_o   (setRst),
        .trig_sw_o   (trigSw),
        .busy_o      (busy),
        .pt_idx_o    (ptIdx),
        .pt_strobe_o (ptStrobe),
        .done_o      (done),
        .err_o       (err)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nVectors++;
        if (actual !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic expectEvent(input int kind, input logic [SW-1:0] step, input logic [IW-1:0] idx);
        exp_t e;
        e.kind = kind;
        e.step = step;
        e.idx  = idx;
        expQ.push_back(e);
    endtask

    task automatic popCheck(input int kind, input logic [SW-1:0] step, input logic [IW-1:0] idx, input string tag);
        exp_t e;
        if (expQ.size() == 0) begin
            nVectors++;
            nMiscompares++;
            $display("[TB] FAIL %s_unexpected: got event kind %0d idx %0d, expected no event", tag, kind, idx);
        end else begin
            e = expQ.pop_front();
            checkOutput({tag, "_kind"}, 64'(kind), 64'(e.kind));
            if (e.kind == K_TRIG) begin
                checkOutput({tag, "_step"}, 64'(step), 64'(e.step));
                checkOutput({tag, "_idx"}, 64'(idx), 64'(e.idx));
            end else if (e.kind == K_STROBE) begin
                checkOutput({tag, "_idx"}, 64'(idx), 64'(e.idx));
            end
        end
    endtask

    // Monitor: any output event the DUT presents is matched against the queue.
    initial begin
        forever begin
            @(negedge clk);
            if (trigSw)         popCheck(K_TRIG, setStep, ptIdx, "trig");
            if (ptStrobe)       popCheck(K_STROBE, '0, ptIdx, "strobe");
            if (done)           popCheck(K_DONE, '0, ptIdx, "done");
            if (err && !prevErr) popCheck(K_ERR, '0, ptIdx, "err");
            prevErr = err;
        end
    end

    // Channel model: raises fina respDelay cycles after each trigger.
    initial begin
        meas = 1'b0;
        forever begin
            @(negedge clk);
            if (trigSw && respMode != 0) begin
                repeat (respDelay) @(negedge clk);
                if (respMode == 1) begin
                    meas = 1'b1;
                    for (int k = 0; k < 100 && !ptStrobe; k++) @(negedge clk);
                    meas = 1'b0;
                end else if (respMode == 2) begin
                    meas = 1'b1;
                    for (int k = 0; k < 2000 && respMode == 2; k++) @(negedge clk);
                    meas = 1'b0;
                end
            end
        end
    end

    task automatic applyStimulus(input logic s, input logic a);
        @(negedge clk);
        start = s;
        abort = a;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic cfgWrite(input logic [7:0] addr, input logic [31:0] data);
        @(negedge clk);
        cfgWe    = 1'b1;
        cfgAddr  = addr;
        cfgWdata = data;
        @(negedge clk);
        cfgWe    = 1'b0;
    endtask

    task automatic configure(input int last, input int settle, input int dwell, input int tmo);
        cfgWrite(8'h00, 32'(last));
        cfgWrite(8'h04, 32'(settle));
        cfgWrite(8'h08, 32'(dwell));
        cfgWrite(8'h0C, 32'(tmo));
    endtask

    // sel: 0 trigger, 1 strobe, 2 error high, 3 done
    task automatic cyclesTo(input int sel, input int budget, output int cnt);
        logic hit;
        cnt = 0;
        hit = 1'b0;
        while (!hit && cnt < budget) begin
            @(negedge clk);
            cnt++;
            hit = (sel == 0 && trigSw) || (sel == 1 && ptStrobe) ||
                  (sel == 2 && err) || (sel == 3 && done);
        end
        if (!hit) begin
            nVectors++;
            nMiscompares++;
            $display("[TB] FAIL wait_event%0d: got no event within %0d cycles, expected one", sel, budget);
            cnt = -1;
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_setStep"}, 64'(setStep), 64'd0);
        checkOutput({tag, "_setRst"}, 64'(setRst), 64'd0);
        checkOutput({tag, "_trig"}, 64'(trigSw), 64'd0);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
        checkOutput({tag, "_ptIdx"}, 64'(ptIdx), 64'd0);
        checkOutput({tag, "_strobe"}, 64'(ptStrobe), 64'd0);
        checkOutput({tag, "_done"}, 64'(done), 64'd0);
        checkOutput({tag, "_err"}, 64'(err), 64'd0);
    endtask

    initial begin
        rst = 1'b1; cfgWe = 1'b0; cfgAddr = '0; cfgWdata = '0; start = 1'b0; abort = 1'b0;
        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        rst = 1'b0;

        // Basic three-point sweep
        cfgWrite(8'h40, 32'h100);
        cfgWrite(8'h44, 32'h200);
        cfgWrite(8'h48, 32'h300);
        configure(2, 3, 5, 0);
        respMode = 1; respDelay = 10;
        expectEvent(K_TRIG, 30'h100, 4'd0); expectEvent(K_STROBE, '0, 4'd0);
        expectEvent(K_TRIG, 30'h200, 4'd1); expectEvent(K_STROBE, '0, 4'd1);
        expectEvent(K_TRIG, 30'h300, 4'd2); expectEvent(K_STROBE, '0, 4'd2);
        expectEvent(K_DONE, '0, 4'd0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("busyAfterStart", 64'(busy), 64'd1);
        checkOutput("setRstAfterStart", 64'(setRst), 64'd1);
        checkOutput("stepInLoad", 64'(setStep), 64'h100);
        cyclesTo(0, 50, n);
        checkOutput("trigLatency", 64'(n + 1), 64'd5);
        checkOutput("setRstAtTrig", 64'(setRst), 64'd0);
        cyclesTo(3, 1000, n);
        @(negedge clk);
        checkOutput("busyAfterDone", 64'(busy), 64'd0);
        checkOutput("idxAfterDone", 64'(ptIdx), 64'd2);

        // Timeout with no measurement
        configure(1, 3, 5, 20);
        respMode = 0;
        expectEvent(K_TRIG, 30'h100, 4'd0); expectEvent(K_ERR, '0, 4'd0);
        expectEvent(K_TRIG, 30'h200, 4'd1); expectEvent(K_DONE, '0, 4'd0);
        applyStimulus(1'b1, 1'b0);
        cyclesTo(0, 50, n);
        cyclesTo(2, 100, n);
        checkOutput("errLatency", 64'(n), 64'd22);
        cyclesTo(3, 1000, n);
        checkOutput("errSticky", 64'(err), 64'd1);

        // Stale fina held high plus a write to the table while busy
        configure(1, 3, 0, 0);
        respMode = 2; respDelay = 10;
        expectEvent(K_TRIG, 30'h100, 4'd0); expectEvent(K_STROBE, '0, 4'd0);
        expectEvent(K_TRIG, 30'h200, 4'd1); expectEvent(K_STROBE, '0, 4'd1);
        expectEvent(K_DONE, '0, 4'd0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("errClearedOnStart", 64'(err), 64'd0);
        cfgWrite(8'h40, 32'h3FF);
        cyclesTo(0, 50, n);
        cyclesTo(0, 100, n);
        cyclesTo(1, 50, n);
        checkOutput("staleBlanking", 64'(n), 64'd4);
        cyclesTo(3, 1000, n);
        respMode = 0;
        repeat (3) @(negedge clk);

        // Abort in WAIT at point 1, then restart
        configure(2, 3, 2, 0);
        respMode = 1; respDelay = 10;
        expectEvent(K_TRIG, 30'h100, 4'd0); expectEvent(K_STROBE, '0, 4'd0);
        expectEvent(K_TRIG, 30'h200, 4'd1);
        applyStimulus(1'b1, 1'b0);
        cyclesTo(0, 50, n);
        cyclesTo(0, 100, n);
        respMode = 0;
        repeat (2) @(negedge clk);
        applyStimulus(1'b0, 1'b1);
        checkOutput("busyAfterAbort", 64'(busy), 64'd0);
        checkOutput("setRstAfterAbort", 64'(setRst), 64'd0);
        checkOutput("errAfterAbort", 64'(err), 64'd0);
        repeat (12) @(negedge clk);
        applyStimulus(1'b1, 1'b1);
        checkOutput("startAbortTogether", 64'(busy), 64'd0);
        respMode = 1;
        expectEvent(K_TRIG, 30'h100, 4'd0); expectEvent(K_STROBE, '0, 4'd0);
        expectEvent(K_TRIG, 30'h200, 4'd1); expectEvent(K_STROBE, '0, 4'd1);
        expectEvent(K_TRIG, 30'h300, 4'd2); expectEvent(K_STROBE, '0, 4'd2);
        expectEvent(K_DONE, '0, 4'd0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("restartIdx", 64'(ptIdx), 64'd0);
        cyclesTo(3, 1000, n);

        // Reset in the middle of LOAD
        configure(2, 10, 0, 0);
        respMode = 0;
        applyStimulus(1'b1, 1'b0);
        repeat (2) @(negedge clk);
        checkOutput("setRstInLoad", 64'(setRst), 64'd1);
        #1 rst = 1'b1;
        #1 checkResetOutputs("midReset");
        @(negedge clk);
        rst = 1'b0;
        respMode = 1; respDelay = 10;
        expectEvent(K_TRIG, 30'h100, 4'd0); expectEvent(K_STROBE, '0, 4'd0);
        expectEvent(K_DONE, '0, 4'd0);
        applyStimulus(1'b1, 1'b0);
        cyclesTo(0, 50, n);
        checkOutput("trigLatencyAfterReset", 64'(n + 1), 64'd2);
        cyclesTo(3, 1000, n);

        // Full table
        for (int i = 0; i < NPTS; i++) cfgWrite(8'(8'h40 + 4 * i), 32'h1000 + 32'(i));
        configure(NPTS - 1, 0, 0, 0);
        respMode = 1; respDelay = 3;
        for (int i = 0; i < NPTS; i++) begin
            expectEvent(K_TRIG, 30'(32'h1000 + 32'(i)), 4'(i));
            expectEvent(K_STROBE, '0, 4'(i));
        end
        expectEvent(K_DONE, '0, 4'd0);
        applyStimulus(1'b1, 1'b0);
        cyclesTo(3, 3000, n);
        checkOutput("finalIdx", 64'(ptIdx), 64'd15);
        repeat (3) @(negedge clk);

        checkOutput("queueDrained", 64'(expQ.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule

// File: doc/asg_sweep_sequencer.md
# asg_sweep_sequencer

Frequency-sweep scheduler for one ASG channel. Holds a table of up to NPTS phase-step words and walks through them. For each point it loads `set_step`, holds the channel in reset for a settle interval, fires a software trigger, waits for the measurement-done flag (`fina`) or a timeout, then dwells before moving to the next point. It sits between the system-bus register block and the ASG channel's `set_step_i` / `set_rst_i` / `trig_sw_i` inputs, replacing the static bus values while a sweep runs.

## Interface
Parameters:
- `RSZ`, 14, buffer address width; step words are RSZ+16 bits.
- `NPTS`, 16, step-table depth (power of 2); `IW = $clog2(NPTS)`.

Ports:
- `dac_clk_i`, in, 1, sole clock.
- `dac_rst_i`, in, 1, reset. Asynchronous, active-high.
- `cfg_we_i`, in, 1, config write strobe, one cycle per write.
- `cfg_addr_i`, in, 8, config byte address.
- `cfg_wdata_i`, in, 32, config write data.
- `start_i`, in, 1, sweep start pulse.
- `abort_i`, in, 1, sweep abort pulse.
- `meas_done_i`, in, 1, measurement-complete level (`fina`) from the channel.
- `set_step_o`, out, RSZ+16, step word to the ASG channel.
- `set_rst_o`, out, 1, ASG channel FSM reset.
- `trig_sw_o`, out, 1, ASG software trigger, single-cycle pulse.
- `busy_o`, out, 1, sweep in progress.
- `pt_idx_o`, out, IW, index of the current point.
- `pt_strobe_o`, out, 1, one-cycle pulse when a point completes successfully.
- `done_o`, out, 1, one-cycle pulse at the end of a sweep.
- `err_o`, out, 1, sticky timeout flag; cleared on `start_i`.

## Operation
- Config map, with fields zero-extended:
  - 0x00: `last_idx[IW-1:0]`
  - 0x04: `settle[15:0]`
  - 0x08: `dwell[31:0]`
  - 0x0C: `timeout[31:0]`
  - 0x40 + 4·i: `step[i][RSZ+15:0]` for i < NPTS
- Other addresses are ignored. All config writes are ignored while `busy_o`=1.
- FSM states: IDLE, LOAD, ARM, WAIT, DWELL, FIN.
  - IDLE: on `start_i`, set idx=0, clear `err_o`, go to LOAD.
  - LOAD: `set_step_o`=step[idx] and `set_rst_o`=1 for settle+1 cycles, then go to ARM.
  - ARM: `set_rst_o`=0, `trig_sw_o`=1 for exactly one cycle, load the timeout counter, go to WAIT.
  - WAIT: ignore `meas_done_i` for the first 2 cycles (lets a stale level from the previous point clear). On `meas_done_i`=1, pulse `pt_strobe_o` and go to DWELL. If the counter reaches 0 first, set `err_o`=1 and go to DWELL with no strobe. timeout=0 disables the timeout.
  - DWELL: count dwell cycles (0 means a single cycle). Then, if idx==last_idx go to FIN; otherwise idx+1 and go to LOAD.
  - FIN: `done_o`=1 for one cycle, go to IDLE.
- Outputs by state:
  - `busy_o`=1 in every state except IDLE.
  - `set_step_o` holds step[idx] from LOAD onward and keeps its last value in IDLE.
- `abort_i` in any busy state: go to IDLE next cycle, drop `set_rst_o` to 0, no `done_o`, `err_o` unchanged.
- `start_i` while busy is ignored. If `start_i` and `abort_i` arrive together in IDLE, abort wins and the FSM stays in IDLE.
- Counters are 32-bit unsigned with no wrap, since they load and count down to 0.
- idx is IW bits; last_idx = NPTS-1 gives the full table with no wrap.

## Timing
- Reset values:
  - `set_step_o`=0, `set_rst_o`=0, `trig_sw_o`=0, `busy_o`=0, `pt_idx_o`=0, `pt_strobe_o`=0, `done_o`=0, `err_o`=0.
  - State=IDLE.
  - Config registers: last_idx=0, settle=0, dwell=0, timeout=0. The table is not reset.
- `start_i` at cycle t: `busy_o`=1 and `set_rst_o`=1 at t+1. `trig_sw_o` fires at t+settle+2.
- `meas_done_i` is registered once, so `pt_strobe_o` rises 2 cycles after `meas_done_i` rises (outside the WAIT blanking window).
- All outputs are registered. The table read is synchronous, one cycle, and is issued in the last cycle of DWELL or at start, so it does not add extra latency.
- A reset assertion mid-sweep immediately returns all outputs to their reset values.

## Structure
- Package `asg_seq_pkg`:
  - state enum `seq_state_e`
  - config address localparams: `SEQ_A_LAST`, `SEQ_A_SETTLE`, `SEQ_A_DWELL`, `SEQ_A_TMO`, `SEQ_A_TBL`
- Sub-module `asg_seq_tbl`: NPTS × (RSZ+16) single-port write, synchronous-read RAM.
- The FSM, counters and config registers live in the top module.

## Test plan
- Basic sweep: last_idx=2, steps 0x100/0x200/0x300, settle=3, dwell=5, with `meas_done_i` 10 cycles after each trigger.
  - `set_step_o` is 0x100, 0x200, 0x300 in sequence.
  - Three `trig_sw_o` pulses, three `pt_strobe_o` pulses, one `done_o`.
  - `trig_sw_o` fires 5 cycles after `start_i`.
- Timeout: timeout=20 and `meas_done_i` held low.
  - `err_o` rises 21–22 cycles after the trigger.
  - The sweep continues; `done_o` still fires and `pt_strobe_o` is never asserted.
- Abort in WAIT at point 1.
  - `busy_o`=0 next cycle, `set_rst_o`=0, no `done_o`.
  - A following `start_i` restarts at idx 0.
- Reset mid-LOAD.
  - All outputs go to reset values asynchronously.
  - Config registers read back as 0, so a restart uses last_idx=0.
- Busy write and stale done:
  - A write to 0x40 during a sweep leaves step[0] unchanged.
  - `meas_done_i` held high from the previous point is ignored during the 2 blanking cycles.
- Full table: last_idx=NPTS-1.
  - NPTS triggers are issued, `pt_idx_o` ends at 15, with no wrap to 0 before `done_o`.
